clk_div_monitor: RTL

Receive-side companion to the fabric clock divider. Samples a divided clock (or any slow square wave) in the fast `clk` domain, measures each half-period in `clk` cycles, and reports edge strobes, the latest measurement, lock status against an expected half-period, and loss of the input. It sits next to the divider output or on an external reference-clock pin. Its status feeds the sequencer and the register block.

---
 rtl/clk_div_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// Half-period monitor for a slow square wave sampled in the clk domain: edge strobes, measurement, lock and loss.
// Optional saturating error counter enabled by defining CLK_DIV_MONITOR_ERRCNT_EN.
//
// state      | meaning
// IDLE       | after reset, waiting for the first (unarmed) edge
// MEASURE    | measuring, counting consecutive good half-periods
// LOCKED     | LOCK_COUNT good half-periods seen, still in tolerance
// LOST       | no edge for TIMEOUT cycles; next edge is unarmed
module clk_div_monitor #(
    parameter int WIDTH      = 17,
    parameter int N          = 50,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic             rise,
    output logic             fall,
    output logic [WIDTH-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [7:0]       err_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    localparam logic [WIDTH-1:0]        CNT_MAX   = '1;
    localparam logic [WIDTH-1:0]        TIMEOUT_V = WIDTH'(TIMEOUT);
    localparam logic signed [WIDTH:0]   N_S       = (WIDTH+1)'(N);
    localparam logic signed [WIDTH:0]   TOL_S     = (WIDTH+1)'(TOL);
    localparam logic [3:0]              LOCK_V    = 4'(LOCK_COUNT);

    logic                    s1, s2, s3;
    logic [WIDTH-1:0]        cnt;
    logic [1:0]              state, state_nxt;
    logic [3:0]              gc, gc_nxt;
    logic                    edge_det;
    logic                    armed;
    logic                    good;
    logic                    timeout;
    logic [WIDTH-1:0]        meas;
    logic signed [WIDTH:0]   diff;

    assign edge_det = s2 ^ s3;
    assign armed    = (state == ST_MEASURE) || (state == ST_LOCKED);
    assign meas     = (cnt == CNT_MAX) ? cnt : cnt + WIDTH'(1);
    assign diff     = $signed({1'b0, meas}) - N_S;
    assign good     = (diff <= TOL_S) && (diff >= -TOL_S);
    // An edge landing on the timeout cycle takes precedence.
    assign timeout  = (cnt == TIMEOUT_V) && !edge_det;

    always_comb begin
        state_nxt = state;
        gc_nxt    = gc;
        case (state)
            ST_IDLE, ST_LOST: begin
                if (edge_det) begin
                    state_nxt = ST_MEASURE;
                    gc_nxt    = 4'd0;
                end else if (timeout) begin
                    state_nxt = ST_LOST;
                end
            end
            ST_MEASURE: begin
                if (edge_det) begin
                    if (good) begin
                        gc_nxt = gc + 4'd1;
                        if (gc + 4'd1 == LOCK_V)
                            state_nxt = ST_LOCKED;
                    end else begin
                        gc_nxt = 4'd0;
                    end
                end else if (timeout) begin
                    state_nxt = ST_LOST;
                end
            end
            default: begin
                if (edge_det) begin
                    if (!good) begin
                        state_nxt = ST_MEASURE;
                        gc_nxt    = 4'd0;
                    end
                end else if (timeout) begin
                    state_nxt = ST_LOST;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            state        <= ST_IDLE;
            gc           <= 4'd0;
            rise         <= 1'b0;
            fall         <= 1'b0;
            period_valid <= 1'b0;
            half_period  <= '0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            s1           <= clk_in;
            s2           <= s1;
            s3           <= s2;
            cnt          <= edge_det ? '0 : meas;
            state        <= state_nxt;
            gc           <= gc_nxt;
            rise         <= edge_det & s2;
            fall         <= edge_det & ~s2;
            period_valid <= edge_det & armed;
            if (edge_det && armed)
                half_period <= meas;
            locked       <= (state_nxt == ST_LOCKED);
            lost         <= (state_nxt == ST_LOST);
        end
    end

`ifdef CLK_DIV_MONITOR_ERRCNT_EN
    logic bad_meas;
    assign bad_meas = edge_det && armed && !good;

    always_ff @(posedge clk) begin
        if (reset)
            err_count <= 8'd0;
        else if (bad_meas && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif

endmodule
